// File: rtl/assert_fail_logger.sv
// assert_fail_logger
// Records every cycle on which one or more assertion checkers fail. Each
// record (failing-checker mask, optionally a cycle timestamp) goes into a
// small first-word-fall-through FIFO drained over a valid/ready port.
// Also keeps sticky per-checker flags, a saturating failure counter and a
// sticky overflow flag for records dropped while the FIFO was full.
//
// Build option: define ASSERT_LOG_TIMESTAMP_EN to build the free-running
// timestamp counter and store it with each record. Without it, records hold
// only the mask and rec_ts is tied to zero. The port list is the same in both
// builds.
module assert_fail_logger #(
  parameter int NUM_CHECKERS = 4,
  parameter int DEPTH        = 8,
  parameter int TS_WIDTH     = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHECKERS-1:0] fail,
  input  logic                    clear,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [NUM_CHECKERS-1:0] rec_mask,
  output logic [TS_WIDTH-1:0]     rec_ts,
  output logic [NUM_CHECKERS-1:0] sticky,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic                    overflow,
  output logic                    any_fail
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [OCC_W-1:0]        occ_reg;
  logic [NUM_CHECKERS-1:0] sticky_reg;
  logic [CNT_WIDTH-1:0]    fail_count_reg;
  logic                    overflow_reg;
  logic [NUM_CHECKERS-1:0] mask_mem [DEPTH];

  logic fail_hit;
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // A failing cycle needs a nonzero fail vector; clear discards it entirely.
  // Pops need a real head (an empty FIFO ignores rec_ready, so a same-cycle
  // push is never popped) and lose against clear. A full FIFO still accepts
  // a push when the head leaves on the same edge.
  always_comb begin
    fail_hit  = (|fail) && !clear;
    fifo_full = (occ_reg == OCC_FULL);
    do_pop    = (occ_reg != '0) && rec_ready && !clear;
    do_push   = fail_hit && (!fifo_full || do_pop);
    do_drop   = fail_hit && fifo_full && !do_pop;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_push && !do_pop)      occ_reg <= occ_reg + 1'b1;
      else if (do_pop && !do_push) occ_reg <= occ_reg - 1'b1;
    end
  end

  // Mask storage; cleared by reset so the stale head reads zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mask_mem[i] <= '0;
    end else if (do_push) begin
      mask_mem[wr_ptr_reg] <= fail;
    end
  end

  // Sticky flags, saturating failure counter and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_reg     <= '0;
      fail_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (clear) begin
      sticky_reg     <= '0;
      fail_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (fail_hit) begin
        sticky_reg <= sticky_reg | fail;
        if (fail_count_reg != '1) fail_count_reg <= fail_count_reg + 1'b1;
      end
      if (do_drop) overflow_reg <= 1'b1;
    end
  end

`ifdef ASSERT_LOG_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_reg;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  // Free-running cycle counter; only reset restarts it, clear leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_reg <= '0;
    else       ts_reg <= ts_reg + 1'b1;
  end

  // Timestamp storage alongside the mask, written with the counter value
  // seen at the failing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
    end else if (do_push) begin
      ts_mem[wr_ptr_reg] <= ts_reg;
    end
  end

  assign rec_ts = ts_mem[rd_ptr_reg];
`else
  assign rec_ts = '0;
`endif

  // Outputs decode registered state only; the head is shown fall-through.
  assign rec_valid  = (occ_reg != '0);
  assign rec_mask   = mask_mem[rd_ptr_reg];
  assign sticky     = sticky_reg;
  assign fail_count = fail_count_reg;
  assign overflow   = overflow_reg;
  assign any_fail   = |sticky_reg;

endmodule

// File: tb/tb_assert_fail_logger.sv
// Testbench for assert_fail_logger: directed stimulus with a record
// scoreboard drained by an independent monitor process.
module tb_assert_fail_logger;

  localparam int NC    = 4;
  localparam int DEPTH = 8;
  localparam int TSW   = 16;
  localparam int CW    = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NC-1:0]  fail;
  logic           clear;
  logic           rec_valid;
  logic           rec_ready;
  logic [NC-1:0]  rec_mask;
  logic [TSW-1:0] rec_ts;
  logic [NC-1:0]  sticky;
  logic [CW-1:0]  fail_count;
  logic           overflow;
  logic           any_fail;

  typedef struct {
    logic [NC-1:0]  m;
    logic [TSW-1:0] t;
  } rec_t;

  rec_t           q[$];
  logic [TSW-1:0] m_ts;
  int             total = 0;
  int             bad   = 0;

  assert_fail_logger #(
    .NUM_CHECKERS(NC), .DEPTH(DEPTH), .TS_WIDTH(TSW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .fail(fail), .clear(clear),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_mask(rec_mask),
    .rec_ts(rec_ts), .sticky(sticky), .fail_count(fail_count),
    .overflow(overflow), .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [TSW-1:0] ets(input logic [TSW-1:0] t);
`ifdef ASSERT_LOG_TIMESTAMP_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the expected record model is updated after the edge.
  task automatic step(input logic [NC-1:0] f, input logic c, input logic r);
    fail = f; clear = c; rec_ready = r;
    @(posedge clk);
    if (c) q.delete();
    else if (f != '0 && q.size() < DEPTH) q.push_back('{m: f, t: ets(m_ts)});
    m_ts++;
    #1;
  endtask

  // Monitor: checks validity against the scoreboard and compares each popped head.
  always @(negedge clk) begin
    if (!reset) begin
      check("rec_valid_vs_model", 32'(rec_valid), 32'(q.size() != 0));
      if (rec_valid && rec_ready && !clear && q.size() > 0) begin
        rec_t e;
        e = q.pop_front();
        check("pop_mask", 32'(rec_mask), 32'(e.m));
        check("pop_ts", 32'(rec_ts), 32'(e.t));
        $display("pop: mask=%b ts=%0d (exp mask=%b ts=%0d)", rec_mask, rec_ts, e.m, e.t);
      end
    end
  end

  initial begin
    logic [TSW-1:0] te;
    reset = 1'b1; fail = '0; clear = 1'b0; rec_ready = 1'b0; m_ts = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_mask", 32'(rec_mask), 32'd0);
    check("rst_ts", 32'(rec_ts), 32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_count", 32'(fail_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_any", 32'(any_fail), 32'd0);
    reset = 1'b0;

    // Single failure at ts=5.
    repeat (5) step('0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    check("s1_valid", 32'(rec_valid), 32'd1);
    check("s1_mask", 32'(rec_mask), 32'b0010);
    check("s1_ts", 32'(rec_ts), 32'(ets(16'd5)));
    check("s1_sticky", 32'(sticky), 32'b0010);
    check("s1_count", 32'(fail_count), 32'd1);
    check("s1_any", 32'(any_fail), 32'd1);
    check("s1_ovf", 32'(overflow), 32'd0);
    step('0, 1'b0, 1'b1);
    check("s1_drained", 32'(rec_valid), 32'd0);

    // 300 consecutive failures: saturation and overflow.
    step('0, 1'b1, 1'b0);
    te = m_ts;
    for (int i = 0; i < 300; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      if (i == 7)   check("s2_ovf_after8", 32'(overflow), 32'd0);
      if (i == 8)   check("s2_ovf_after9", 32'(overflow), 32'd1);
      if (i == 253) check("s2_count254", 32'(fail_count), 32'd254);
      if (i == 254) check("s2_count255", 32'(fail_count), 32'd255);
    end
    check("s2_count_sat", 32'(fail_count), 32'd255);
    check("s2_head_ts", 32'(rec_ts), 32'(ets(te)));
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b1);
    check("s2_drained", 32'(rec_valid), 32'd0);

    // Full FIFO with simultaneous pop and push.
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0100, 1'b0, 1'b0);
    check("s3_ovf_full", 32'(overflow), 32'd0);
    check("s3_count8", 32'(fail_count), 32'd8);
    step(4'b0001, 1'b0, 1'b1);
    check("s3_ovf_pp", 32'(overflow), 32'd0);
    check("s3_count9", 32'(fail_count), 32'd9);
    for (int i = 0; i < 8; i++) begin
      step('0, 1'b0, 1'b1);
      if (i == 6) check("s3_occ8_left1", 32'(rec_valid), 32'd1);
    end
    check("s3_drained", 32'(rec_valid), 32'd0);

    // Clear beats a concurrent failure and pop.
    repeat (3) step(4'b0011, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    check("s4_valid", 32'(rec_valid), 32'd0);
    check("s4_sticky", 32'(sticky), 32'd0);
    check("s4_count", 32'(fail_count), 32'd0);
    check("s4_ovf", 32'(overflow), 32'd0);
    check("s4_any", 32'(any_fail), 32'd0);
    step('0, 1'b0, 1'b0);
    te = m_ts;
    step(4'b0001, 1'b0, 1'b0);
    check("s4_ts_continues", 32'(rec_ts), 32'(ets(te)));
    step('0, 1'b0, 1'b1);

    // Reset mid-drain with records queued.
    repeat (5) step(4'b0101, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    rec_ready = 1'b0;
    reset = 1'b1;
    #2;
    check("s5_valid", 32'(rec_valid), 32'd0);
    check("s5_mask", 32'(rec_mask), 32'd0);
    check("s5_ts", 32'(rec_ts), 32'd0);
    check("s5_sticky", 32'(sticky), 32'd0);
    check("s5_count", 32'(fail_count), 32'd0);
    check("s5_any", 32'(any_fail), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ts = '0;
    repeat (3) step('0, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    check("s5_mask_after", 32'(rec_mask), 32'b1001);
    check("s5_ts_after", 32'(rec_ts), 32'(ets(16'd3)));
    check("s5_count_after", 32'(fail_count), 32'd1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assert_fail_logger.md
# assert_fail_logger

Collects the per-cycle failure pulses of the bound hardware assertion checkers and records each failing cycle in a small readout FIFO. Each record holds the failing-checker mask and a cycle timestamp. Sits directly downstream of the assertion checker modules; their fail outputs are OR-free wired into `fail`. Provides sticky flags, a saturating failure counter, and a valid/ready drain port toward the debug/readout logic.

## Interface

Parameters:
- `NUM_CHECKERS`, 4: number of checker fail inputs (1..16).
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TS_WIDTH`, 16: timestamp width.
- `CNT_WIDTH`, 8: failure counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; all state cleared.
- `fail`, in, NUM_CHECKERS: bit i high means checker i failed this cycle; sampled every edge.
- `clear`, in, 1: synchronous clear of the log state.
- `rec_valid`, out, 1: FIFO head is valid.
- `rec_ready`, in, 1: consumer accepts the head.
- `rec_mask`, out, NUM_CHECKERS: fail vector of the head record.
- `rec_ts`, out, TS_WIDTH: timestamp of the head record.
- `sticky`, out, NUM_CHECKERS: OR of all fail vectors since the last reset or clear.
- `fail_count`, out, CNT_WIDTH: number of failing cycles, saturating.
- `overflow`, out, 1: sticky; set when a record was dropped because the FIFO was full.
- `any_fail`, out, 1: OR of `sticky`.

## Operation

- Failing cycle: an edge where `fail != 0` and `clear` is low.
- On each failing cycle:
  - `sticky |= fail`.
  - `fail_count` increments by 1 and holds at its all-ones value.
  - A push of {`fail`, `ts`} into the FIFO is attempted. `ts` is the free-running cycle counter value at that edge.
- Timestamp counter:
  - Increments every cycle and wraps modulo 2^TS_WIDTH.
  - Cleared only by `reset`; `clear` does not touch it.
- FIFO:
  - Circular buffer with a read pointer, a write pointer and an occupancy count.
  - Output is first-word-fall-through: `rec_*` show the head whenever `rec_valid` is high.
  - Pop happens on an edge where `rec_valid && rec_ready`.
- Full FIFO:
  - Push without a simultaneous pop: the record is dropped and `overflow` is set.
  - Push with a simultaneous pop: the push is accepted and occupancy is unchanged.
- Empty FIFO:
  - `rec_ready` is ignored.
  - A push and a `rec_ready` in the same cycle do not pop the new entry.
- `rec_mask`/`rec_ts` are don't-care while `rec_valid` is low. The implementation drives the stale head.
- `clear` high at an edge:
  - Zeroes `sticky`, `fail_count`, `overflow` and the FIFO pointers.
  - `clear` wins over a concurrent `fail`; that cycle's failure is discarded entirely.
  - `clear` wins over a concurrent pop.
- `reset` asserted mid-operation: all registers go to zero immediately. Records held in the FIFO are lost.

## Timing

- Reset values: `rec_valid`=0, `rec_mask`=0, `rec_ts`=0, `sticky`=0, `fail_count`=0, `overflow`=0, `any_fail`=0; timestamp counter = 0.
- The first edge after reset deassertion samples `fail` with `ts`=0.
- Latency is 1 cycle from a failing edge to `sticky`, `fail_count` and `any_fail` updating.
- Latency is 1 cycle from a failing edge to `rec_valid` rising, if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Valid/ready: once `rec_valid` is high, it and the head fields stay stable until popped, or until `clear`/`reset`.
- All outputs are registered or decode registered state only; there is no combinational path from `fail` or `rec_ready` to any output.

## Configuration

- `ASSERT_LOG_TIMESTAMP_EN` defined:
  - The timestamp counter is built.
  - Each FIFO entry stores NUM_CHECKERS+TS_WIDTH bits.
  - `rec_ts` carries the recorded timestamp.
- `ASSERT_LOG_TIMESTAMP_EN` undefined:
  - No counter and no timestamp storage.
  - Entries store NUM_CHECKERS bits only.
  - `rec_ts` is tied to 0.
  - The port list is unchanged, and all other behaviour is identical.

## Test plan

- Reset, then `fail`=4'b0010 at cycle 5 (`ts`=5) with `rec_ready`=0 -> next cycle: `rec_valid`=1, `rec_mask`=0010, `rec_ts`=5, `sticky`=0010, `fail_count`=1, `any_fail`=1.
- `fail`=4'b1111 for 300 consecutive cycles with CNT_WIDTH=8 -> `fail_count` saturates at 255.
  - With `rec_ready`=0, 8 records are stored and `overflow`=1 from the 9th failing cycle onward.
  - Draining yields the 8 oldest timestamps in order.
- FIFO full with `rec_ready`=1 and `fail`=0001 in the same cycle -> the head is popped, the new record is appended, `overflow` stays 0, and occupancy stays 8.
- `clear` and `fail`=1000 on the same edge, with 3 records queued -> next cycle: `rec_valid`=0, `sticky`=0, `fail_count`=0, `overflow`=0. The timestamp continues without reset.
- `reset` pulsed mid-drain with 5 records queued -> all outputs are 0 while asserted. After release, the first record has `ts` counted from 0.
- Build without `ASSERT_LOG_TIMESTAMP_EN` and repeat scenario 1 -> same mask, `fail_count` and `sticky`; `rec_ts`=0.
